// File: rtl/hispi_packet_tx.sv
// hispi_packet_tx
// Packetized-SP HiSPi transmitter: frames 4-lane, 10-bit pixel words with
// SOF/SOL/EOL/EOF sync packets and fill-word blanking. One word per lane per
// clk, meant to feed a 10:1 DDR serializer (MSB first).
//
// Ports
//   clk           word clock
//   reset_async   asynchronous active-high reset
//   enable        level; permits frame starts (sampled in IDLE and at EOF)
//   pix_in        4 pixels, lane i on [10i+9:10i]
//   pix_in_valid  pix_in holds valid data
//   pix_in_ready  tx accepts pix_in this cycle (exactly the ACTIVE cycles)
//   lane_data     lane i word on [10i+9:10i]
//   frame_active  high from first SOF word through last EOF word
//   sof_pulse     high on the cycle the SOF code word is driven
//   line_count    current/last line index
//   underrun      sticky: a pixel was required but pix_in_valid was low
//
// Timing model: state_q/cnt_q describe the word being built this cycle; that
// word is registered into lane_data_q, so lane_data lags the FSM by one
// cycle. A pixel accepted in cycle N therefore appears on lane_data at N+1.

module hispi_packet_tx #(
    parameter int          LINE_WORDS   = 576,
    parameter int          LINES        = 1296,
    parameter int          HBLANK_WORDS = 16,
    parameter int          VBLANK_WORDS = 64,
    parameter logic [9:0]  FILL_WORD    = 10'h001
) (
    input  logic        clk,
    input  logic        reset_async,
    input  logic        enable,
    input  logic [39:0] pix_in,
    input  logic        pix_in_valid,
    output logic        pix_in_ready,
    output logic [39:0] lane_data,
    output logic        frame_active,
    output logic        sof_pulse,
    output logic [15:0] line_count,
    output logic        underrun
);

    // One shared word counter; sync packets need at least 0..3.
    localparam int CNT_MAX0 = (LINE_WORDS > 4) ? LINE_WORDS : 4;
    localparam int CNT_MAX1 = (HBLANK_WORDS > CNT_MAX0) ? HBLANK_WORDS : CNT_MAX0;
    localparam int CNT_MAX  = (VBLANK_WORDS > CNT_MAX1) ? VBLANK_WORDS : CNT_MAX1;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int LINE_W   = (LINES > 1) ? $clog2(LINES) : 1;

    // Last-count values, guarded so a zero-length state never yields -1.
    localparam int LW_LAST = (LINE_WORDS > 0) ? LINE_WORDS - 1 : 0;
    localparam int HB_LAST = (HBLANK_WORDS > 0) ? HBLANK_WORDS - 1 : 0;
    localparam int VB_LAST = (VBLANK_WORDS > 0) ? VBLANK_WORDS - 1 : 0;
    localparam int LN_LAST = (LINES > 0) ? LINES - 1 : 0;

    localparam logic [9:0] CODE_SOF = 10'h003;
    localparam logic [9:0] CODE_SOL = 10'h001;
    localparam logic [9:0] CODE_EOF = 10'h007;
    localparam logic [9:0] CODE_EOL = 10'h005;

    typedef enum logic [2:0] {
        IDLE,
        VBLANK,
        SYNC_S,
        ACTIVE,
        SYNC_E,
        HBLANK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [39:0]         lane_data_q, lane_data_d;
    logic                underrun_q, underrun_d;
    logic                sof_pulse_q, sof_pulse_d;
    logic                ready_q;
    logic                frame_active_q;

    // Sync packet: 3FF, 000, 000, CODE.
    function automatic logic [9:0] sync_word(input logic [CNT_W-1:0] c,
                                             input logic [9:0] code);
        logic [9:0] w;
        w = code;
        if (c == CNT_W'(0))
            w = 10'h3FF;
        else if (c == CNT_W'(1) || c == CNT_W'(2))
            w = 10'h000;
        return w;
    endfunction

    // A 000 pixel would extend a zero run into sync territory; lift it to 001.
    function automatic logic [9:0] clamp_pix(input logic [9:0] px);
        return (px == 10'h000) ? 10'h001 : px;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        lane_data_d = {4{FILL_WORD}};
        underrun_d  = underrun_q;
        sof_pulse_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    if (VBLANK_WORDS > 0) begin
                        state_d = VBLANK;
                    end else begin
                        state_d = SYNC_S;
                        line_d  = '0;
                    end
                end
            end

            VBLANK: begin
                if (cnt_q == CNT_W'(VB_LAST)) begin
                    state_d = SYNC_S;
                    cnt_d   = '0;
                    line_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SYNC_S: begin
                lane_data_d = {4{sync_word(cnt_q, (line_q == '0) ? CODE_SOF : CODE_SOL)}};
                sof_pulse_d = (cnt_q == CNT_W'(3)) && (line_q == '0);
                if (cnt_q == CNT_W'(3)) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ACTIVE: begin
                // Missing pixel: emit fill in the slot, line length unchanged.
                if (pix_in_valid) begin
                    for (int i = 0; i < 4; i++)
                        lane_data_d[10*i +: 10] = clamp_pix(pix_in[10*i +: 10]);
                end else begin
                    underrun_d = 1'b1;
                end
                if (cnt_q == CNT_W'(LW_LAST)) begin
                    state_d = SYNC_E;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SYNC_E: begin
                lane_data_d = {4{sync_word(cnt_q, (line_q == LINE_W'(LN_LAST)) ? CODE_EOF : CODE_EOL)}};
                if (cnt_q == CNT_W'(3)) begin
                    cnt_d = '0;
                    if (line_q == LINE_W'(LN_LAST)) begin
                        // line_count holds LINES-1 until the next SOF.
                        if (!enable) begin
                            state_d = IDLE;
                        end else if (VBLANK_WORDS > 0) begin
                            state_d = VBLANK;
                        end else begin
                            state_d = SYNC_S;
                            line_d  = '0;
                        end
                    end else begin
                        line_d  = line_q + LINE_W'(1);
                        state_d = (HBLANK_WORDS > 0) ? HBLANK : SYNC_S;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HBLANK: begin
                if (cnt_q == CNT_W'(HB_LAST)) begin
                    state_d = SYNC_S;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            line_q         <= '0;
            lane_data_q    <= {4{FILL_WORD}};
            underrun_q     <= 1'b0;
            sof_pulse_q    <= 1'b0;
            ready_q        <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            line_q         <= line_d;
            lane_data_q    <= lane_data_d;
            underrun_q     <= underrun_d;
            sof_pulse_q    <= sof_pulse_d;
            // ready_q mirrors state_q == ACTIVE but comes straight from a flop.
            ready_q        <= (state_d == ACTIVE);
            // The word built in state_q lands on lane_data next, so framing
            // follows state_q: rises with SOF's 3FF, falls after EOF's code.
            frame_active_q <= (state_q != IDLE) && (state_q != VBLANK);
        end
    end

    assign lane_data    = lane_data_q;
    assign pix_in_ready = ready_q;
    assign frame_active = frame_active_q;
    assign sof_pulse    = sof_pulse_q;
    assign line_count   = 16'(line_q);
    assign underrun     = underrun_q;

endmodule
